// File: rtl/byte_bus_lsu.sv
// Load/store unit bridging 32-bit MEM-stage accesses onto an 8-bit memory bus.
// Accesses are split into 1/2/4 little-endian byte beats; loads are re-assembled and extended.
module byte_bus_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata
);

  // Handshakes: a request transfers on a cycle with req_valid && req_ready;
  // a bus beat completes on a cycle with bus_valid && bus_ready, and all bus_*
  // outputs hold steady from the first cycle of a beat until it completes.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              req_bad;
  logic [1:0]        last_cnt;
  logic [31:0]       load_ext;

  assign req_bad = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && (req_addr[1:0] != 2'b00));

  always_comb begin
    last_cnt = 2'd3;
    if (size_q == 2'd0) last_cnt = 2'd0;
    else if (size_q == 2'd1) last_cnt = 2'd1;
  end

  always_comb begin
    load_ext = rdata_q;
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & rdata_q[7]}}, rdata_q[7:0]};
      2'd1:    load_ext = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    size_d    = size_q;
    signed_d  = signed_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = 8'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          err_d    = req_bad;
          cnt_d    = 2'd0;
          rdata_d  = 32'd0;
          state_d  = req_bad ? DONE : XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q + ADDR_W'(cnt_q);
        bus_wdata = wdata_q[8*cnt_q +: 8];
        if (bus_ready) begin
          if (!we_q) rdata_d[8*cnt_q +: 8] = bus_rdata;
          if (cnt_q == last_cnt) state_d = DONE;
          else cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        // Stores and rejected accesses report zero data.
        if (!we_q && !err_q) rsp_rdata = load_ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_byte_bus_lsu.sv
// Directed bench for byte_bus_lsu: a driver pushes expected beats and responses,
// a bus responder and a response monitor pop and compare them independently.
module tb_byte_bus_lsu;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;

  byte_bus_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // {read byte, we, addr, wdata}
  logic [48:0] beat_q[$];
  int          stall_q[$];
  // {err, rdata}
  logic [32:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit bus_nocheck = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // bus responder: compares every presented beat against the head of beat_q
  initial begin
    bus_ready = 1'b0;
    bus_rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_ready = 1'b0;
      end else if (bus_valid) begin
        if (bus_nocheck) begin
          bus_ready = 1'b1;
          bus_rdata = 8'd0;
        end else if (beat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected: got beat addr %0h expected no beat", bus_addr);
          bus_ready = 1'b1;
        end else begin
          check("bus_beat", {bus_we, bus_addr, bus_wdata}, beat_q[0][40:0]);
          if (stall_q[0] > 0) begin
            stall_q[0] = stall_q[0] - 1;
            bus_ready = 1'b0;
          end else begin
            bus_ready = 1'b1;
            bus_rdata = beat_q[0][48:41];
            void'(beat_q.pop_front());
            void'(stall_q.pop_front());
          end
        end
      end else begin
        bus_ready = 1'b1;
      end
    end
  end

  // response monitor
  initial begin
    int a;
    int l;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata %0h err %0b expected no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          check("rsp_data", {rsp_err, rsp_rdata}, e);
          check("rsp_latency", cyc - a, l);
        end
      end
    end
  end

  // driver: present request, wait for acceptance, push expectations; leaves req_valid high
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rbytes, input logic [31:0] exp_rd,
                        input logic exp_err, input int stall_beat, input int stall_len,
                        output int acc);
    int n;
    int t;
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept: got req_ready 0 for 50 cycles expected 1");
      acc = -1;
      return;
    end
    acc = cyc;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (exp_err) n = 0;
    for (int k = 0; k < n; k++) begin
      beat_q.push_back({rbytes[8*k +: 8], we, addr + 32'(k), wdata[8*k +: 8]});
      stall_q.push_back((k == stall_beat) ? stall_len : 0);
    end
    exp_q.push_back({exp_err, exp_rd});
    acc_q.push_back(cyc);
    lat_q.push_back(exp_err ? 1 : n + 1 + stall_len);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int a0, a1, a2, t;
    bit found;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("rst_bus_out", {bus_we, bus_addr, bus_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    // word store, little-endian beats
    do_req(1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, -1, 0, a0);
    idle(6);
    // byte loads, signed and unsigned
    do_req(0, 0, 1, 32'h203, 0, 32'h80, 32'hFFFFFF80, 0, -1, 0, a0);
    idle(3);
    do_req(0, 0, 0, 32'h203, 0, 32'h80, 32'h00000080, 0, -1, 0, a0);
    idle(3);
    // half load with three wait cycles on beat 1
    do_req(0, 1, 1, 32'h0, 0, 32'h9234, 32'hFFFF9234, 0, 1, 3, a0);
    idle(8);
    do_req(0, 1, 0, 32'h0, 0, 32'h9234, 32'h00009234, 0, -1, 0, a0);
    idle(4);
    do_req(0, 2, 1, 32'h400, 0, 32'h84332211, 32'h84332211, 0, 0, 2, a0);
    idle(8);
    do_req(1, 1, 0, 32'h202, 32'hABCD1234, 0, 0, 0, -1, 0, a0);
    idle(4);
    do_req(1, 0, 0, 32'h7, 32'h000055AA, 0, 0, 0, -1, 0, a0);
    idle(3);
    // rejected accesses: no beats, error on cycle 1
    do_req(0, 1, 0, 32'h101, 0, 0, 0, 1, -1, 0, a0);
    idle(2);
    do_req(0, 2, 1, 32'h102, 0, 0, 0, 1, -1, 0, a0);
    idle(2);
    do_req(0, 3, 0, 32'h0, 0, 0, 0, 1, -1, 0, a0);
    idle(2);
    do_req(1, 2, 0, 32'h1, 32'h12345678, 0, 0, 1, -1, 0, a0);
    idle(2);

    // reset during beat 2 of a word store
    bus_nocheck = 1;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 0;
    t = 0;
    while (!found && t < 10) begin
      if (bus_valid && bus_addr == 32'h302) found = 1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    check("rst_mid_reached_beat2", found, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_bus_valid", bus_valid, 0);
    check("rst_mid_idle", {req_ready, busy, rsp_valid}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    bus_nocheck = 0;
    do_req(1, 2, 0, 32'h300, 32'h01020304, 0, 0, 0, -1, 0, a0);
    idle(6);

    // back-to-back byte stores with req_valid held; later values presented while busy
    do_req(1, 0, 0, 32'h10, 32'h11, 0, 0, 0, -1, 0, a0);
    do_req(1, 0, 0, 32'h11, 32'h22, 0, 0, 0, -1, 0, a1);
    do_req(1, 0, 0, 32'h12, 32'h33, 0, 0, 0, -1, 0, a2);
    idle(4);
    check("b2b_spacing_1", a1 - a0, 3);
    check("b2b_spacing_2", a2 - a1, 3);

    t = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_rsp", exp_q.size(), 0);
    check("drain_beats", beat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
